// File: rtl/rca_pkg.sv
// Shared helpers for the pipelined ripple-carry adder: chunk sizing, config check, overflow rule.
// Latency: none (package only).
// Backpressure: not applicable.
package rca_pkg;

    // Width of one ripple slice; guarded so a bad STAGES still elaborates far enough to report.
    function automatic int rca_cw(input int width, input int stages);
        return (stages > 0) ? width / stages : width;
    endfunction

    // Legal configurations split the operand evenly into 1..WIDTH slices.
    function automatic bit rca_cfg_ok(input int width, input int stages);
        return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
    endfunction

    // Signed overflow from sign bits: same-signed operands producing a differently signed result.
    function automatic logic rca_ovf(input logic msb_a, input logic msb_b_eff, input logic msb_s);
        return (msb_a == msb_b_eff) && (msb_s != msb_a);
    endfunction

endpackage

// File: rtl/pipelined_rca_if.sv
// Operand/result handshake bundle for pipelined_rca.
// Latency: none (wires only).
// Backpressure: out_ready from the sink, in_ready back to the source.
interface pipelined_rca_if #(
    parameter int WIDTH = 16
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    // Source/sink side: drives operations and result acceptance.
    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    // Adder side.
    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/rca_slice.sv
// CW-bit combinational ripple of full adders; also exposes the carry into the MSB for overflow.
// Latency: 0 cycles (pure combinational).
// Backpressure: not applicable.
module rca_slice #(
    parameter int CW = 4
) (
    input  logic [CW-1:0] a,
    input  logic [CW-1:0] b,
    input  logic          c_in,
    output logic [CW-1:0] s,
    output logic          c_out,
    output logic          c_msb_in
);
    logic [CW:0] c;

    // Ripple the carry bit by bit through CW full adders.
    always_comb begin
        s    = '0;
        c    = '0;
        c[0] = c_in;
        for (int i = 0; i < CW; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign c_out    = c[CW];
    assign c_msb_in = c[CW-1];
endmodule

// File: rtl/pipelined_rca.sv
// Pipelined ripple-carry add/sub: STAGES slices of CW bits with the carry registered between slices.
// Latency: STAGES cycles from accept to out_valid; one result per cycle when unstalled.
// Backpressure: a held output (out_valid && !out_ready) freezes the whole pipe and drops in_ready.
module pipelined_rca
    import rca_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    pipelined_rca_if.slave io
);
    localparam int CW = rca_cw(WIDTH, STAGES);

    if (!rca_cfg_ok(WIDTH, STAGES)) begin : g_cfg_check
        $error("pipelined_rca: WIDTH must be a multiple of STAGES with 1 <= STAGES <= WIDTH");
    end

    logic              adv;
    logic [STAGES-1:0] vld_q;
    logic [STAGES-1:0] carry_vec;
    logic [WIDTH-1:0]  b_eff;
    logic [WIDTH-1:0]  sum_out;
    logic              ovf_q;

    // Single global advance: the pipe only moves when the last slot is empty or being taken.
    assign adv          = !vld_q[STAGES-1] || io.out_ready;
    assign io.in_ready  = adv;
    assign io.out_valid = vld_q[STAGES-1];
    assign io.sum       = sum_out;
    assign io.cout      = carry_vec[STAGES-1];
    assign io.ovf       = ovf_q;

    // Subtract inverts B once at capture so only the effective operand travels down the pipe.
    assign b_eff = io.sub ? ~io.b : io.b;

    // Valid bits shift alongside the data; bubbles travel as cleared slots.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q <= '0;
        end else if (adv) begin
            vld_q[0] <= io.in_valid;
            for (int k = 1; k < STAGES; k++) begin
                vld_q[k] <= vld_q[k-1];
            end
        end
    end

    for (genvar j = 0; j < STAGES; j++) begin : g_stage
        localparam int DD = STAGES - j;

        logic [CW-1:0] a_in;
        logic [CW-1:0] b_in;
        logic [CW-1:0] s_c;
        logic          c_in;
        logic          c_out;
        logic          c_msb;
        logic          c_q;
        logic [CW-1:0] s_d [DD];

        if (j == 0) begin : g_head
            assign a_in = io.a[CW-1:0];
            assign b_in = b_eff[CW-1:0];
            assign c_in = io.cin;
        end else begin : g_skew
            logic [CW-1:0] a_d [j];
            logic [CW-1:0] b_d [j];

            // Delay chunk j by j cycles so it reaches its slice together with the incoming carry.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    for (int i = 0; i < j; i++) begin
                        a_d[i] <= '0;
                        b_d[i] <= '0;
                    end
                end else if (adv) begin
                    a_d[0] <= io.a[j*CW +: CW];
                    b_d[0] <= b_eff[j*CW +: CW];
                    for (int i = 1; i < j; i++) begin
                        a_d[i] <= a_d[i-1];
                        b_d[i] <= b_d[i-1];
                    end
                end
            end

            assign a_in = a_d[j-1];
            assign b_in = b_d[j-1];
            assign c_in = carry_vec[j-1];
        end

        rca_slice #(.CW(CW)) u_slice (
            .a        (a_in),
            .b        (b_in),
            .c_in     (c_in),
            .s        (s_c),
            .c_out    (c_out),
            .c_msb_in (c_msb)
        );

        // Register this slice's carry and hold its sum chunk until the upper chunks catch up.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                c_q <= 1'b0;
                for (int i = 0; i < DD; i++) begin
                    s_d[i] <= '0;
                end
            end else if (adv) begin
                c_q    <= c_out;
                s_d[0] <= s_c;
                for (int i = 1; i < DD; i++) begin
                    s_d[i] <= s_d[i-1];
                end
            end
        end

        assign carry_vec[j]            = c_q;
        assign sum_out[j*CW +: CW]     = s_d[DD-1];

        if (j == STAGES - 1) begin : g_tail
            // Overflow only exists at the top slice: carry into the MSB against carry out of it.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    ovf_q <= 1'b0;
                end else if (adv) begin
                    ovf_q <= c_msb ^ c_out;
                end
            end
        end else begin : g_mid
            logic c_msb_unused;
            assign c_msb_unused = c_msb;
        end
    end
endmodule
